// File: rtl/rtc_set_ctrl.sv
// rtl/rtc_set_ctrl.sv - BCD time-of-day register with run/hold control and validated field loads
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   run_en     level; 0 freezes counting
//   time_in    BCD {tens, units} for the field being set (asynchronous switches)
//   set_hour   rising edge loads hours        (asynchronous level)
//   set_minute rising edge loads minutes      (asynchronous level)
//   set_second rising edge loads seconds      (asynchronous level)
//   set_mil    rising edge loads centiseconds (asynchronous level)
//   time_out   BCD {HH, MM, SS, CC}
//   field_sel  one-hot {hour, min, sec, mil} of the highest-priority set input held
//   holding    1 while the counter is frozen
//   load_err   sticky flag, set by a rejected load, cleared by an accepted one
//   day_pulse  one-cycle pulse on the 23:59:59.99 -> 00:00:00.00 wrap
module rtc_set_ctrl #(
   parameter int PRESCALE = 500000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run_en,
   input  logic [7:0]  time_in,
   input  logic        set_hour,
   input  logic        set_minute,
   input  logic        set_second,
   input  logic        set_mil,
   output logic [31:0] time_out,
   output logic [3:0]  field_sel,
   output logic        holding,
   output logic        load_err,
   output logic        day_pulse
);

   localparam int PW = $clog2(PRESCALE);
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   typedef enum logic {ST_RUN, ST_HOLD} state_t;

   state_t        state_q, state_d;
   logic [3:0]    set_s1, set_s2, set_d;
   logic [7:0]    time_s1, time_s2;
   logic [PW-1:0] pre;
   logic [7:0]    hh, mm, ss, cc;

   logic [3:0]    set_rise, load_sel;
   logic [7:0]    load_lim;
   logic          load_ok, cnt_en, tick;
   logic          cc_w, ss_w, mm_w, hh_w;

   function automatic logic [3:0] prio_onehot(input logic [3:0] v);
      if (v[3])      return 4'b1000;
      else if (v[2]) return 4'b0100;
      else if (v[1]) return 4'b0010;
      else if (v[0]) return 4'b0001;
      else           return 4'b0000;
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      else                return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // Bit order everywhere: [3]=hour [2]=minute [1]=second [0]=mil
   assign set_rise  = set_s2 & ~set_d;
   assign load_sel  = prio_onehot(set_rise);
   assign field_sel = prio_onehot(set_s2);

   always_comb begin
      load_lim = 8'h99;
      if (load_sel[3])                    load_lim = 8'h23;
      else if (load_sel[2] | load_sel[1]) load_lim = 8'h59;
   end

   assign load_ok = (time_s2[7:4] <= 4'd9) && (time_s2[3:0] <= 4'd9) &&
                    (time_s2 <= load_lim);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_RUN;
      else        state_q <= state_d;
   end

   // Any held set input forces HOLD, so a load edge can never coincide with a tick.
   always_comb begin
      state_d = ST_HOLD;
      if (run_en && (set_s2 == 4'b0000)) state_d = ST_RUN;
   end

   assign holding = (state_q == ST_HOLD);
   assign cnt_en  = (state_d == ST_RUN);
   assign tick    = cnt_en && (pre == PRE_LAST);

   assign cc_w = (cc == 8'h99);
   assign ss_w = (ss == 8'h59);
   assign mm_w = (mm == 8'h59);
   assign hh_w = (hh == 8'h23);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         set_s1    <= '0;
         set_s2    <= '0;
         set_d     <= '0;
         time_s1   <= '0;
         time_s2   <= '0;
         pre       <= '0;
         hh        <= '0;
         mm        <= '0;
         ss        <= '0;
         cc        <= '0;
         load_err  <= 1'b0;
         day_pulse <= 1'b0;
      end else begin
         set_s1  <= {set_hour, set_minute, set_second, set_mil};
         set_s2  <= set_s1;
         set_d   <= set_s2;
         time_s1 <= time_in;
         time_s2 <= time_s1;

         // Leaving RUN discards the partial period.
         if (!cnt_en || pre == PRE_LAST) pre <= '0;
         else                            pre <= pre + 1'b1;

         day_pulse <= tick && cc_w && ss_w && mm_w && hh_w;

         if (tick) begin
            cc <= cc_w ? 8'h00 : bcd_inc(cc);
            if (cc_w)
               ss <= ss_w ? 8'h00 : bcd_inc(ss);
            if (cc_w && ss_w)
               mm <= mm_w ? 8'h00 : bcd_inc(mm);
            if (cc_w && ss_w && mm_w)
               hh <= hh_w ? 8'h00 : bcd_inc(hh);
         end else if (load_sel != 4'b0000) begin
            if (load_ok) begin
               load_err <= 1'b0;
               case (load_sel)
                  4'b1000: hh <= time_s2;
                  4'b0100: mm <= time_s2;
                  4'b0010: ss <= time_s2;
                  default: cc <= time_s2;
               endcase
            end else begin
               load_err <= 1'b1;
            end
         end
      end
   end

   assign time_out = {hh, mm, ss, cc};

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// tb/tb_rtc_set_ctrl.sv - directed self-checking bench for rtc_set_ctrl
module tb_rtc_set_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run_en;
   logic [7:0]  time_in;
   logic [3:0]  set_v;
   logic [31:0] time_out;
   logic [3:0]  field_sel;
   logic        holding, load_err, day_pulse;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   rtc_set_ctrl #(.PRESCALE(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .run_en     (run_en),
      .time_in    (time_in),
      .set_hour   (set_v[3]),
      .set_minute (set_v[2]),
      .set_second (set_v[1]),
      .set_mil    (set_v[0]),
      .time_out   (time_out),
      .field_sel  (field_sel),
      .holding    (holding),
      .load_err   (load_err),
      .day_pulse  (day_pulse)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold the set inputs for 6 edges, release, then let synchronizers drain.
   task automatic do_load(input logic [3:0] sel, input logic [7:0] val);
      time_in = val;
      set_v   = sel;
      edges(6);
      set_v   = 4'b0000;
      edges(3);
   endtask

   initial begin
      rst_n   = 1'b0;
      run_en  = 1'b1;
      time_in = 8'h00;
      set_v   = 4'b0000;
      edges(3);
      check("rst_time", time_out, 32'h0);
      check("rst_sel", {28'h0, field_sel}, 32'h0);
      check("rst_hold", {31'h0, holding}, 32'h0);
      check("rst_err", {31'h0, load_err}, 32'h0);
      check("rst_day", {31'h0, day_pulse}, 32'h0);

      // Free run from reset release
      rst_n = 1'b1;
      edges(3);
      check("run_3clk", time_out, 32'h00000000);
      edges(1);
      check("run_4clk", time_out, 32'h00000001);
      edges(36);
      check("run_40clk", time_out, 32'h00000010);
      edges(360);
      check("run_400clk", time_out, 32'h00000100);
      check("run_hold", {31'h0, holding}, 32'h0);

      // Hour load while running: commit on the third edge
      time_in = 8'h23;
      set_v   = 4'b1000;
      edges(2);
      check("hr_pre", time_out, 32'h00000100);
      check("hr_sel", {28'h0, field_sel}, 32'h8);
      edges(1);
      check("hr_load", time_out, 32'h23000100);
      check("hr_hold", {31'h0, holding}, 32'h1);
      check("hr_err", {31'h0, load_err}, 32'h0);
      edges(3);
      check("hr_frozen", time_out, 32'h23000100);
      set_v  = 4'b0000;
      run_en = 1'b0;
      edges(3);
      check("hr_idle_hold", {31'h0, holding}, 32'h1);

      // Field validation
      do_load(4'b0100, 8'h60);
      check("mm60_time", time_out, 32'h23000100);
      check("mm60_err", {31'h0, load_err}, 32'h1);
      do_load(4'b0100, 8'h59);
      check("mm59_time", time_out, 32'h23590100);
      check("mm59_err", {31'h0, load_err}, 32'h0);
      do_load(4'b0001, 8'h1A);
      check("cc1a_time", time_out, 32'h23590100);
      check("cc1a_err", {31'h0, load_err}, 32'h1);

      // Day wrap
      do_load(4'b1000, 8'h23);
      do_load(4'b0100, 8'h59);
      do_load(4'b0010, 8'h59);
      do_load(4'b0001, 8'h99);
      check("wrap_set", time_out, 32'h23595999);
      check("wrap_err", {31'h0, load_err}, 32'h0);
      run_en = 1'b1;
      edges(3);
      check("wrap_pre", time_out, 32'h23595999);
      check("wrap_pre_day", {31'h0, day_pulse}, 32'h0);
      edges(1);
      check("wrap_time", time_out, 32'h00000000);
      check("wrap_day", {31'h0, day_pulse}, 32'h1);
      edges(1);
      check("wrap_day_end", {31'h0, day_pulse}, 32'h0);
      run_en = 1'b0;

      // Simultaneous hour+second edges: only hour acted on, second not queued
      time_in = 8'h12;
      set_v   = 4'b1010;
      edges(2);
      check("pri_sel", {28'h0, field_sel}, 32'h8);
      edges(1);
      check("pri_load", time_out, 32'h12000000);
      edges(3);
      set_v = 4'b0010;
      edges(3);
      check("pri_sel_sec", {28'h0, field_sel}, 32'h2);
      check("pri_noqueue", time_out, 32'h12000000);
      set_v = 4'b0000;
      edges(3);
      do_load(4'b0001, 8'hA0);
      check("ccA0_err", {31'h0, load_err}, 32'h1);
      check("ccA0_time", time_out, 32'h12000000);

      // run_en dropped mid-period
      run_en = 1'b1;
      edges(10);
      check("mid_run", time_out, 32'h12000002);
      run_en = 1'b0;
      edges(2);
      check("mid_hold", {31'h0, holding}, 32'h1);
      check("mid_frozen", time_out, 32'h12000002);
      run_en = 1'b1;
      edges(3);
      check("mid_3clk", time_out, 32'h12000002);
      edges(1);
      check("mid_4clk", time_out, 32'h12000003);

      // Asynchronous reset between edges
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_time", time_out, 32'h0);
      check("arst_err", {31'h0, load_err}, 32'h0);
      check("arst_hold", {31'h0, holding}, 32'h0);
      check("arst_sel", {28'h0, field_sel}, 32'h0);
      check("arst_day", {31'h0, day_pulse}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
